// File: rtl/morse_glyph_renderer_pkg.sv
// morse_pkg: shared types and the character-to-Morse lookup table for
// morse_glyph_renderer. Pattern bit i = 1 means symbol i is a dash.
package morse_pkg;

   localparam int CHAR_W  = 6;
   localparam int MAX_SYM = 5;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] bits;
   } morse_pat_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_GAP,
      ST_HOLD
   } play_state_t;

   // Table entries are written in reading order, left aligned (first symbol in
   // the MSB, 1 = dash); the loop at the end flips them so that symbol 0 lands
   // in bit 0. Codes 36..63 are blank (len 0).
   function automatic morse_pat_t morse_lookup(input logic [CHAR_W-1:0] code);
      logic [2:0] n;
      logic [4:0] w;
      morse_pat_t p;
      n = 3'd0;
      w = 5'b00000;
      case (code)
         6'd0:  {n, w} = {3'd2, 5'b01000}; // A .-
         6'd1:  {n, w} = {3'd4, 5'b10000}; // B -...
         6'd2:  {n, w} = {3'd4, 5'b10100}; // C -.-.
         6'd3:  {n, w} = {3'd3, 5'b10000}; // D -..
         6'd4:  {n, w} = {3'd1, 5'b00000}; // E .
         6'd5:  {n, w} = {3'd4, 5'b00100}; // F ..-.
         6'd6:  {n, w} = {3'd3, 5'b11000}; // G --.
         6'd7:  {n, w} = {3'd4, 5'b00000}; // H ....
         6'd8:  {n, w} = {3'd2, 5'b00000}; // I ..
         6'd9:  {n, w} = {3'd4, 5'b01110}; // J .---
         6'd10: {n, w} = {3'd3, 5'b10100}; // K -.-
         6'd11: {n, w} = {3'd4, 5'b01000}; // L .-..
         6'd12: {n, w} = {3'd2, 5'b11000}; // M --
         6'd13: {n, w} = {3'd2, 5'b10000}; // N -.
         6'd14: {n, w} = {3'd3, 5'b11100}; // O ---
         6'd15: {n, w} = {3'd4, 5'b01100}; // P .--.
         6'd16: {n, w} = {3'd4, 5'b11010}; // Q --.-
         6'd17: {n, w} = {3'd3, 5'b01000}; // R .-.
         6'd18: {n, w} = {3'd3, 5'b00000}; // S ...
         6'd19: {n, w} = {3'd1, 5'b10000}; // T -
         6'd20: {n, w} = {3'd3, 5'b00100}; // U ..-
         6'd21: {n, w} = {3'd4, 5'b00010}; // V ...-
         6'd22: {n, w} = {3'd3, 5'b01100}; // W .--
         6'd23: {n, w} = {3'd4, 5'b10010}; // X -..-
         6'd24: {n, w} = {3'd4, 5'b10110}; // Y -.--
         6'd25: {n, w} = {3'd4, 5'b11000}; // Z --..
         6'd26: {n, w} = {3'd5, 5'b11111}; // 0 -----
         6'd27: {n, w} = {3'd5, 5'b01111}; // 1 .----
         6'd28: {n, w} = {3'd5, 5'b00111}; // 2 ..---
         6'd29: {n, w} = {3'd5, 5'b00011}; // 3 ...--
         6'd30: {n, w} = {3'd5, 5'b00001}; // 4 ....-
         6'd31: {n, w} = {3'd5, 5'b00000}; // 5 .....
         6'd32: {n, w} = {3'd5, 5'b10000}; // 6 -....
         6'd33: {n, w} = {3'd5, 5'b11000}; // 7 --...
         6'd34: {n, w} = {3'd5, 5'b11100}; // 8 ---..
         6'd35: {n, w} = {3'd5, 5'b11110}; // 9 ----.
         default: {n, w} = {3'd0, 5'b00000};
      endcase
      p.len = n;
      for (int i = 0; i < MAX_SYM; i++) begin
         p.bits[i] = w[MAX_SYM-1-i];
      end
      return p;
   endfunction

endpackage

// File: rtl/morse_glyph_renderer_if.sv
// Character handshake bus between the keypad/decoder (master) and
// morse_glyph_renderer (slave).
interface morse_glyph_renderer_if;
   import morse_pkg::*;

   logic              char_valid;
   logic [CHAR_W-1:0] char_code;
   logic              char_ready;

   modport master (output char_valid, output char_code, input char_ready);
   modport slave  (input char_valid, input char_code, output char_ready);

endinterface

// File: rtl/morse_glyph_renderer_slot_geom.sv
// morse_slot_geom: purely combinational hit test for one slot. Reports whether
// the current pixel lies inside the slot's box and inside its (dot or dash) mark.
// All coordinates are widened to 11 bits so nothing wraps at x = 1023.
module morse_slot_geom #(
   parameter int X0     = 80,
   parameter int PITCH  = 100,
   parameter int BOX_W  = 60,
   parameter int Y0     = 200,
   parameter int BOX_H  = 80,
   parameter int MARK_H = 20,
   parameter int DOT_W  = 20,
   parameter int DASH_W = 40
) (
   input  logic [7:0] slot,
   input  logic [9:0] CounterX,
   input  logic [9:0] CounterY,
   input  logic       is_dash,
   output logic       in_box,
   output logic       in_mark
);

   logic [10:0] x, y, box_x, mark_w, mark_x, mark_y;

   assign x      = {1'b0, CounterX};
   assign y      = {1'b0, CounterY};
   assign box_x  = 11'(X0) + 11'(slot) * 11'(PITCH);
   assign mark_w = is_dash ? 11'(DASH_W) : 11'(DOT_W);
   // Centring offsets: half the slack on each side of the mark.
   assign mark_x = box_x + ((11'(BOX_W) - mark_w) >> 1);
   assign mark_y = 11'(Y0) + 11'((BOX_H - MARK_H) / 2);

   assign in_box  = (x >= box_x) && (x < box_x + 11'(BOX_W)) &&
                    (y >= 11'(Y0)) && (y < 11'(Y0) + 11'(BOX_H));
   assign in_mark = (x >= mark_x) && (x < mark_x + mark_w) &&
                    (y >= mark_y) && (y < mark_y + 11'(MARK_H));

endmodule

// File: rtl/morse_glyph_renderer.sv
// morse_glyph_renderer: latches a character code through a valid/ready
// handshake, looks up its Morse pattern and draws SLOTS boxes with dot/dash
// marks onto the VGA pixel stream (pixel outputs registered, 1 clk latency).
// Define MORSE_PLAYBACK_EN for symbol-by-symbol playback with tone_out/busy.
module morse_glyph_renderer
   import morse_pkg::*;
#(
   parameter int SLOTS    = 5,
   parameter int X0       = 80,
   parameter int PITCH    = 100,
   parameter int BOX_W    = 60,
   parameter int Y0       = 200,
   parameter int BOX_H    = 80,
   parameter int MARK_H   = 20,
   parameter int DOT_W    = 20,
   parameter int DASH_W   = 40,
   parameter int TICK_DIV = 6250000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   morse_glyph_renderer_if.slave  char_bus,
   input  logic [9:0]             CounterX,
   input  logic [9:0]             CounterY,
   input  logic                   inDisplayArea,
   output logic                   vga_r,
   output logic                   vga_g,
   output logic                   vga_b,
   output logic                   tone_out,
   output logic                   busy
);

   if (SLOTS < MAX_SYM || TICK_DIV < 1) begin : g_cfg_check
      $error("morse_glyph_renderer: SLOTS must be >= 5 and TICK_DIV >= 1");
   end

   logic             ready;
   logic             acc;
   morse_pat_t       pat_in;
   logic [2:0]       len_q;
   logic [4:0]       bits_q;
   logic [SLOTS-1:0] reveal, sound, show, dash, in_box, in_mark;

   assign char_bus.char_ready = ready;
   assign acc    = char_bus.char_valid && ready;
   assign pat_in = morse_lookup(char_bus.char_code);

   // Pattern latch: every accepted code replaces len/bits (blank codes give len 0).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q  <= 3'd0;
         bits_q <= 5'd0;
      end else if (acc) begin
         len_q  <= pat_in.len;
         bits_q <= pat_in.bits;
      end
   end

`ifdef MORSE_PLAYBACK_EN
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   play_state_t      state_q, state_d;
   logic [2:0]       slot_q, slot_d, slot_nx;
   logic [1:0]       units_q, units_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic [7:0]       bits_ext;

   assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign slot_nx  = slot_q + 3'd1;
   assign bits_ext = {3'b000, bits_q};
   assign ready    = (state_q == ST_IDLE) || (state_q == ST_HOLD);
   assign busy     = (state_q == ST_MARK) || (state_q == ST_GAP);

   // Playback state register; tone_out is registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         slot_q   <= 3'd0;
         units_q  <= 2'd0;
         cnt_q    <= '0;
         tone_out <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         units_q  <= units_d;
         cnt_q    <= cnt_d;
         tone_out <= (state_d == ST_MARK);
      end
   end

   // Next-state logic: units_q counts the extra units a dash still owes.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      units_d = units_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (acc) begin
               cnt_d  = '0;
               slot_d = 3'd0;
               if (pat_in.len == 3'd0) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_MARK;
                  units_d = pat_in.bits[0] ? 2'd2 : 2'd0;
               end
            end
         end
         ST_MARK: begin
            if (tick) begin
               cnt_d = '0;
               if (units_q == 2'd0) state_d = ST_GAP;
               else                 units_d = units_q - 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (tick) begin
               cnt_d = '0;
               if (slot_q == len_q - 3'd1) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_MARK;
                  slot_d  = slot_nx;
                  units_d = bits_ext[slot_nx] ? 2'd2 : 2'd0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Slots reveal progressively during playback; HOLD shows the whole pattern.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         reveal[i] = (state_q == ST_HOLD) ||
                     (((state_q == ST_MARK) || (state_q == ST_GAP)) && (int'(slot_q) >= i));
         sound[i]  = (state_q == ST_MARK) && (int'(slot_q) == i);
         show[i]   = reveal[i] && (int'(len_q) > i);
      end
   end
`else
   assign ready    = 1'b1;
   assign busy     = 1'b0;
   assign tone_out = 1'b0;

   // Without playback every slot of the latched pattern is shown at once.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         reveal[i] = 1'b1;
         sound[i]  = 1'b0;
         show[i]   = reveal[i] && (int'(len_q) > i);
      end
   end
`endif

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      if (i < MAX_SYM) begin : g_sym
         assign dash[i] = bits_q[i];
      end else begin : g_pad
         assign dash[i] = 1'b0;
      end

      morse_slot_geom #(
         .X0     (X0),
         .PITCH  (PITCH),
         .BOX_W  (BOX_W),
         .Y0     (Y0),
         .BOX_H  (BOX_H),
         .MARK_H (MARK_H),
         .DOT_W  (DOT_W),
         .DASH_W (DASH_W)
      ) u_geom (
         .slot     (8'(i)),
         .CounterX (CounterX),
         .CounterY (CounterY),
         .is_dash  (dash[i]),
         .in_box   (in_box[i]),
         .in_mark  (in_mark[i])
      );
   end

   // Pixel colour register: sounding mark is red only, shown mark adds R+G over blue box.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vga_r <= 1'b0;
         vga_g <= 1'b0;
         vga_b <= 1'b0;
      end else if (|(in_mark & show & sound)) begin
         vga_r <= inDisplayArea;
         vga_g <= 1'b0;
         vga_b <= 1'b0;
      end else begin
         vga_r <= inDisplayArea && (|(in_mark & show));
         vga_g <= inDisplayArea && (|(in_mark & show));
         vga_b <= inDisplayArea && (|in_box);
      end
   end

endmodule
